// File: rtl/yarp_mem_arb.sv
// Shares the single YARP memory port between instruction fetch and data load/store.
// One transaction in flight; data has priority, bounded by a fetch starvation counter.
module yarp_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rd_data_i
);

  localparam logic [1:0] WORD_ACCESS  = 2'b11;
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
  localparam logic       OWNER_FETCH  = 1'b0;
  localparam logic       OWNER_DATA   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_byte_en_q, mem_byte_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;

  logic        data_win_s;
  logic        instr_win_s;
  logic        instr_gnt_s;
  logic        data_gnt_s;
  logic        instr_rvalid_s;
  logic        data_rvalid_s;

  // Saturating increment of the consecutive-data-win count.
  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    if (cnt < STARVE_LIMIT) begin
      return cnt + 4'd1;
    end else begin
      return STARVE_LIMIT;
    end
  endfunction

  // Winner selection: data first unless fetch has waited STARVE_MAX data wins.
  always_comb begin
    data_win_s  = 1'b0;
    instr_win_s = 1'b0;
    if (data_req_i && (starve_q < STARVE_LIMIT)) begin
      data_win_s = 1'b1;
    end else if (instr_req_i) begin
      instr_win_s = 1'b1;
    end else if (data_req_i) begin
      data_win_s = 1'b1;
    end else begin
      data_win_s  = 1'b0;
      instr_win_s = 1'b0;
    end
  end

  // Next-state, command latch and grant/response pulse generation.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    owner_d        = owner_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_byte_en_d  = mem_byte_en_q;
    mem_wr_d       = mem_wr_q;
    mem_wr_data_d  = mem_wr_data_q;
    instr_gnt_s    = 1'b0;
    data_gnt_s     = 1'b0;
    instr_rvalid_s = 1'b0;
    data_rvalid_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_win_s) begin
          instr_gnt_s   = 1'b1;
          owner_d       = OWNER_FETCH;
          mem_req_d     = 1'b1;
          mem_addr_d    = instr_addr_i;
          mem_byte_en_d = WORD_ACCESS;
          mem_wr_d      = 1'b0;
          mem_wr_data_d = 32'h0000_0000;
          starve_d      = 4'd0;
          state_d       = REQ;
        end else if (data_win_s) begin
          data_gnt_s    = 1'b1;
          owner_d       = OWNER_DATA;
          mem_req_d     = 1'b1;
          mem_addr_d    = data_addr_i;
          mem_byte_en_d = data_byte_en_i;
          mem_wr_d      = data_wr_i;
          mem_wr_data_d = data_wr_data_i;
          starve_d      = instr_req_i ? starve_inc(starve_q) : 4'd0;
          state_d       = REQ;
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          // Stores complete on grant; only reads wait for a response.
          state_d   = mem_wr_q ? IDLE : RESP;
        end else begin
          mem_req_d = 1'b1;
          state_d   = REQ;
        end
      end

      RESP: begin
        if (mem_rvalid_i) begin
          instr_rvalid_s = (owner_q == OWNER_FETCH);
          data_rvalid_s  = (owner_q == OWNER_DATA);
          state_d        = IDLE;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      starve_q      <= 4'd0;
      owner_q       <= OWNER_FETCH;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      mem_byte_en_q <= 2'b00;
      mem_wr_q      <= 1'b0;
      mem_wr_data_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      owner_q       <= owner_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wr_q      <= mem_wr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  // Pulses are suppressed while reset is held so nothing leaks in the reset cycle.
  assign instr_gnt_o    = instr_gnt_s    & ~reset;
  assign data_gnt_o     = data_gnt_s     & ~reset;
  assign instr_rvalid_o = instr_rvalid_s & ~reset;
  assign data_rvalid_o  = data_rvalid_s  & ~reset;

  assign instr_rdata_o  = mem_rd_data_i;
  assign data_rdata_o   = mem_rd_data_i;

  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_byte_en_o  = mem_byte_en_q;
  assign mem_wr_o       = mem_wr_q;
  assign mem_wr_data_o  = mem_wr_data_q;

endmodule

// File: tb/tb_yarp_mem_arb.sv
// Testbench for yarp_mem_arb: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, occupancy and response routing.
module tb_yarp_mem_arb;

  localparam int SM = 4;
  localparam logic [1:0] BYTE_ACCESS = 2'b00;
  localparam logic [1:0] HALF_ACCESS = 2'b01;
  localparam logic [1:0] WORD_ACCESS = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [1:0]  data_byte_en_i;
  logic        data_wr_i;
  logic [31:0] data_wr_data_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_wr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rd_data_i;

  int tests_run = 0;
  int tests_failed = 0;

  yarp_mem_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_en_i(data_byte_en_i),
    .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_addr_i = 32'h0; data_byte_en_i = 2'b00;
    data_wr_i = 1'b0; data_wr_data_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rd_data_i = 32'h0;
  endtask

  task automatic do_reset();
    cyc(); clear_inputs(); reset = 1'b1;
    cyc(); cyc(); reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); clear_inputs(); reset = 1'b1;
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    smp();
    tests_run++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_pulses: got %b want 0000", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
    end
    cyc(); smp();
    tests_run++;
    if ({mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o} !== 68'h0) begin
      tests_failed++; $display("FAIL reset_mem_outputs: got req=%b addr=%h be=%b wr=%b wd=%h want all 0", mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o);
    end
    cyc(); clear_inputs(); reset = 1'b0; smp();
    tests_run++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b00000) begin
      tests_failed++; $display("FAIL reset_idle: got %b want 00000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
    end
  endtask

  task automatic test_fetch();
    do_reset();
    cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100; smp();
    tests_run++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o} !== 3'b100) begin
      tests_failed++; $display("FAIL fetch_gnt: got gnt_i/gnt_d/req=%b want 100", {instr_gnt_o, data_gnt_o, mem_req_o});
    end
    cyc(); instr_req_i = 1'b0; instr_addr_i = 32'hFFFF_FFFC; mem_gnt_i = 1'b1; smp();
    tests_run++;
    if ({mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o} !== {1'b1, 32'h0000_0100, WORD_ACCESS, 1'b0, 32'h0}) begin
      tests_failed++; $display("FAIL fetch_cmd: got req=%b addr=%h be=%b wr=%b wd=%h want 1 00000100 11 0 0", mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o);
    end
    cyc(); mem_gnt_i = 1'b0; smp();
    tests_run++;
    if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin
      tests_failed++; $display("FAIL fetch_wait: got req/rv_i/rv_d=%b want 000", {mem_req_o, instr_rvalid_o, data_rvalid_o});
    end
    cyc(); mem_rvalid_i = 1'b1; mem_rd_data_i = 32'hDEAD_BEEF; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL fetch_resp: got rv_i=%b rv_d=%b rdata=%h want 1 0 deadbeef", instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
    cyc(); mem_rvalid_i = 1'b0; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      tests_failed++; $display("FAIL fetch_rv_once: got %b want 00", {instr_rvalid_o, data_rvalid_o});
    end
  endtask

  task automatic test_store();
    do_reset();
    cyc(); data_req_i = 1'b1; data_addr_i = 32'h10; data_wr_data_i = 32'h0000_00AB;
    data_byte_en_i = BYTE_ACCESS; data_wr_i = 1'b1; smp();
    tests_run++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      tests_failed++; $display("FAIL store_gnt: got %b want 01", {instr_gnt_o, data_gnt_o});
    end
    cyc(); data_req_i = 1'b0; data_addr_i = 32'h0; data_wr_data_i = 32'h0; data_wr_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      mem_gnt_i = (k == 3);
      smp();
      tests_run++;
      if ({mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o} !== {1'b1, 32'h10, BYTE_ACCESS, 1'b1, 32'hAB}) begin
        tests_failed++; $display("FAIL store_hold[%0d]: got req=%b addr=%h be=%b wr=%b wd=%h want 1 10 00 1 ab", k, mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o);
      end
    end
    // Back in IDLE: a fetch is granted at once and the stray rvalid goes nowhere.
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h300; smp();
    tests_run++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b01000) begin
      tests_failed++; $display("FAIL store_done: got req/gi/gd/rvi/rvd=%b want 01000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
    end
  endtask

  task automatic test_starvation();
    logic [9:0] got = 10'h0;
    logic [9:0] want = 10'h0;
    int ngrants = 0;
    int both = 0;
    int consec = 0;
    do_reset();
    // Expected order from the rule: fetch wins once data has won SM times in a row.
    for (int k = 0; k < 10; k++) begin
      if (consec < SM) begin want = {want[8:0], 1'b0}; consec++; end
      else begin want = {want[8:0], 1'b1}; consec = 0; end
    end
    cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h200;
    data_req_i = 1'b1; data_wr_i = 1'b1; data_addr_i = 32'h40; data_wr_data_i = 32'h1;
    data_byte_en_i = HALF_ACCESS; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int c = 0; c < 80 && ngrants < 10; c++) begin
      if (c > 0) cyc();
      smp();
      if (instr_gnt_o && data_gnt_o) both++;
      if (instr_gnt_o || data_gnt_o) begin
        got = {got[8:0], instr_gnt_o};
        ngrants++;
      end
    end
    tests_run++;
    if (ngrants !== 10) begin
      tests_failed++; $display("FAIL starve_count: got %0d grants want 10", ngrants);
    end
    tests_run++;
    if (got !== want) begin
      tests_failed++; $display("FAIL starve_order: got %b want %b (1=fetch)", got, want);
    end
    tests_run++;
    if (both !== 0) begin
      tests_failed++; $display("FAIL starve_dual_gnt: got %0d want 0", both);
    end
  endtask

  task automatic test_load();
    do_reset();
    cyc(); data_req_i = 1'b1; data_addr_i = 32'h20; data_byte_en_i = HALF_ACCESS; data_wr_i = 1'b0;
    data_wr_data_i = 32'h5555_5555; smp();
    tests_run++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      tests_failed++; $display("FAIL load_gnt: got %b want 01", {instr_gnt_o, data_gnt_o});
    end
    cyc(); data_req_i = 1'b0; mem_gnt_i = 1'b1; smp();
    tests_run++;
    if ({mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o} !== {1'b1, 32'h20, HALF_ACCESS, 1'b0}) begin
      tests_failed++; $display("FAIL load_cmd: got req=%b addr=%h be=%b wr=%b want 1 20 01 0", mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o);
    end
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rd_data_i = 32'h8000_00FF; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o, data_rdata_o} !== {2'b01, 32'h8000_00FF}) begin
      tests_failed++; $display("FAIL load_resp: got rv_i=%b rv_d=%b rdata=%h want 0 1 800000ff", instr_rvalid_o, data_rvalid_o, data_rdata_o);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    cyc(); mem_rvalid_i = 1'b1; smp();
    tests_run++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b00000) begin
      tests_failed++; $display("FAIL spur_idle: got %b want 00000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
    end
    cyc(); mem_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h44; smp();
    tests_run++;
    if (instr_gnt_o !== 1'b1) begin
      tests_failed++; $display("FAIL spur_still_idle: got gnt_i=%b want 1", instr_gnt_o);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(); instr_req_i = 1'b0; mem_rvalid_i = (k == 0); smp();
      tests_run++;
      if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin
        tests_failed++; $display("FAIL spur_req[%0d]: got req/rvi/rvd=%b want 100", k, {mem_req_o, instr_rvalid_o, data_rvalid_o});
      end
    end
    cyc(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; smp();
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rd_data_i = 32'h1234_5678; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'h1234_5678}) begin
      tests_failed++; $display("FAIL spur_resp: got rvi=%b rvd=%b rdata=%h want 1 0 12345678", instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h80; smp();
    cyc(); instr_req_i = 1'b0; mem_gnt_i = 1'b1; smp();
    cyc(); mem_gnt_i = 1'b0; reset = 1'b1; mem_rvalid_i = 1'b1; mem_rd_data_i = 32'hCAFE_0001; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      tests_failed++; $display("FAIL rst_resp_pulse: got %b want 00", {instr_rvalid_o, data_rvalid_o});
    end
    cyc(); reset = 1'b0; mem_rvalid_i = 1'b0; smp();
    tests_run++;
    if ({mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 72'h0) begin
      tests_failed++; $display("FAIL rst_resp_outputs: got req=%b addr=%h be=%b rv=%b want all 0", mem_req_o, mem_addr_o, mem_byte_en_o, {instr_rvalid_o, data_rvalid_o});
    end
    cyc(); mem_rvalid_i = 1'b1; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      tests_failed++; $display("FAIL rst_resp_late_rv: got %b want 00", {instr_rvalid_o, data_rvalid_o});
    end
    cyc(); mem_rvalid_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h90; data_byte_en_i = WORD_ACCESS; smp();
    tests_run++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      tests_failed++; $display("FAIL rst_resp_new_gnt: got %b want 01", {instr_gnt_o, data_gnt_o});
    end
    cyc(); data_req_i = 1'b0; mem_gnt_i = 1'b1; smp();
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rd_data_i = 32'h0BAD_F00D; smp();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o, data_rdata_o} !== {2'b01, 32'h0BAD_F00D}) begin
      tests_failed++; $display("FAIL rst_resp_new_rv: got rvi=%b rvd=%b rdata=%h want 0 1 0badf00d", instr_rvalid_o, data_rvalid_o, data_rdata_o);
    end
  endtask

  task automatic test_random();
    bit          busy = 1'b0;
    bit          resp_ph = 1'b0;
    bit          own_data = 1'b0;
    bit          cur_wr = 1'b0;
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] cur_wd = 32'h0;
    logic [1:0]  cur_be = 2'b00;
    int          wait_cnt = 0;
    int          consec = 0;
    int          sel;
    bit          i_taken = 1'b1;
    bit          d_taken = 1'b1;
    bit          exp_ig, exp_dg;
    logic [1:0]  exp_rv;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (i_taken || !instr_req_i) begin
        instr_req_i = ($urandom_range(0, 2) != 0);
        instr_addr_i = $urandom;
      end
      if (d_taken || !data_req_i) begin
        data_req_i = ($urandom_range(0, 2) != 0);
        data_addr_i = $urandom;
        data_wr_data_i = $urandom;
        data_wr_i = ($urandom_range(0, 1) != 0);
        sel = $urandom_range(0, 2);
        data_byte_en_i = (sel == 2) ? WORD_ACCESS : 2'(sel);
      end
      i_taken = 1'b0;
      d_taken = 1'b0;
      mem_gnt_i = (busy && !resp_ph) ? (wait_cnt == 0) : ($urandom_range(0, 7) == 0);
      mem_rvalid_i = (busy && resp_ph) ? (wait_cnt == 0) : ($urandom_range(0, 5) == 0);
      mem_rd_data_i = $urandom;
      smp();

      exp_ig = 1'b0;
      exp_dg = 1'b0;
      if (!busy) begin
        if (data_req_i && consec < SM) exp_dg = 1'b1;
        else if (instr_req_i) exp_ig = 1'b1;
        else if (data_req_i) exp_dg = 1'b1;
      end
      tests_run++;
      if ({instr_gnt_o, data_gnt_o} !== {exp_ig, exp_dg}) begin
        tests_failed++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", c, {instr_gnt_o, data_gnt_o}, {exp_ig, exp_dg});
      end
      tests_run++;
      if (mem_req_o !== (busy && !resp_ph)) begin
        tests_failed++; $display("FAIL rnd_req cyc %0d: got %b want %b", c, mem_req_o, busy && !resp_ph);
      end
      if (busy && !resp_ph) begin
        tests_run++;
        if ({mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o} !== {cur_addr, cur_be, cur_wr, cur_wd}) begin
          tests_failed++; $display("FAIL rnd_cmd cyc %0d: got %h %b %b %h want %h %b %b %h", c, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o, cur_addr, cur_be, cur_wr, cur_wd);
        end
      end
      exp_rv = (busy && resp_ph && mem_rvalid_i) ? (own_data ? 2'b01 : 2'b10) : 2'b00;
      tests_run++;
      if ({instr_rvalid_o, data_rvalid_o} !== exp_rv) begin
        tests_failed++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", c, {instr_rvalid_o, data_rvalid_o}, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        tests_run++;
        if ((own_data ? data_rdata_o : instr_rdata_o) !== mem_rd_data_i) begin
          tests_failed++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", c, own_data ? data_rdata_o : instr_rdata_o, mem_rd_data_i);
        end
      end

      if (!busy) begin
        if (exp_ig || exp_dg) begin
          busy = 1'b1;
          resp_ph = 1'b0;
          wait_cnt = $urandom_range(0, 3);
          if (exp_ig) begin
            own_data = 1'b0; cur_addr = instr_addr_i; cur_be = WORD_ACCESS;
            cur_wr = 1'b0; cur_wd = 32'h0; consec = 0; i_taken = 1'b1;
          end else begin
            own_data = 1'b1; cur_addr = data_addr_i; cur_be = data_byte_en_i;
            cur_wr = data_wr_i; cur_wd = data_wr_data_i; d_taken = 1'b1;
            consec = instr_req_i ? ((consec < SM) ? consec + 1 : consec) : 0;
          end
        end
      end else if (!resp_ph) begin
        if (mem_gnt_i) begin
          if (cur_wr) busy = 1'b0;
          else begin resp_ph = 1'b1; wait_cnt = $urandom_range(0, 3); end
        end else wait_cnt--;
      end else begin
        if (mem_rvalid_i) busy = 1'b0;
        else wait_cnt--;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_starvation();
    test_load();
    test_spurious();
    test_reset_in_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/yarp_mem_arb.md
# yarp_mem_arb

Two-port arbiter that shares the single YARP memory port between instruction fetch and the data-memory interface's load/store requests. It sits between those requesters and the memory. It accepts one transaction at a time, holds the command stable until the memory grants it, and routes the read response back to the owner. Data has fixed priority, and a starvation counter guarantees fetch progress.

## Interface
- STARVE_MAX, default 4: consecutive data wins allowed while fetch is pending before fetch is forced to win; legal range 1..15.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- instr_req_i  in  1  fetch request; held with its address until instr_gnt_o
- instr_addr_i  in  32  fetch address; always a word read
- instr_gnt_o  out  1  one-cycle pulse: fetch command latched
- instr_rvalid_o  out  1  one-cycle pulse: instr_rdata_o valid
- instr_rdata_o  out  32  fetch read data (= mem_rd_data_i)
- data_req_i  in  1  load/store request; held with its fields until data_gnt_o
- data_addr_i  in  32  load/store address
- data_byte_en_i  in  2  access size, yarp_pkg access_byte_t encoding, passed through unchanged
- data_wr_i  in  1  1 = store, 0 = load
- data_wr_data_i  in  32  store data
- data_gnt_o  out  1  one-cycle pulse: data command latched
- data_rvalid_o  out  1  one-cycle pulse: load data valid (loads only)
- data_rdata_o  out  32  load read data, unextended (= mem_rd_data_i)
- mem_req_o  out  1  memory request, registered
- mem_addr_o  out  32  latched address
- mem_byte_en_o  out  2  latched size; fetch forces WORD_ACCESS
- mem_wr_o  out  1  latched write flag; 0 for fetch
- mem_wr_data_o  out  32  latched store data; 0 for fetch
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  read response valid
- mem_rd_data_i  in  32  read response data

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is present, select the winner.
  - Latch the winner's command into the mem_* registers, pulse its gnt, record owner, go to REQ.
  - Otherwise stay in IDLE.
- Winner selection:
  - Data wins if data_req_i and starve_cnt < STARVE_MAX.
  - Otherwise fetch wins if instr_req_i.
  - Otherwise data wins if data_req_i.
- REQ:
  - Hold mem_req_o=1 and all mem_* fields stable until mem_gnt_i.
  - On grant with mem_wr_o=1 (store): drop mem_req_o, go to IDLE. No response is returned.
  - On grant for a read: drop mem_req_o, go to RESP.
- RESP:
  - Wait for mem_rvalid_i.
  - On mem_rvalid_i, pulse the owner's rvalid in the same cycle (combinational from mem_rvalid_i and owner), then go to IDLE.
  - The other port's rvalid stays 0.
- starve_cnt (4 bits), updated only on an IDLE grant:
  - Data grant while instr_req_i=1: increment, saturating at STARVE_MAX.
  - Fetch grant: clear to 0.
  - Data grant while instr_req_i=0: clear to 0.
- Ignored inputs:
  - mem_rvalid_i outside RESP is ignored, with no rvalid pulse.
  - mem_gnt_i outside REQ is ignored.
- Requests arriving in REQ/RESP wait; there is no gnt until the FSM returns to IDLE.
- Only one transaction is outstanding at a time.

## Timing
- Reset values:
  - State IDLE, starve_cnt=0, owner=fetch.
  - All outputs 0: mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o, both gnt, both rvalid.
  - instr_rdata_o and data_rdata_o are pure pass-through, not reset.
- Request accept:
  - Request seen in IDLE at cycle t gives gnt at t (combinational) and mem_req_o=1 from t+1.
  - The requester may drop its request or change fields at t+1.
- Store: mem_gnt_i at cycle g gives mem_req_o=0 at g+1 and IDLE at g+1. Minimum store occupancy is 2 cycles.
- Read: mem_gnt_i at g gives RESP at g+1; mem_rvalid_i at r ≥ g+1 gives owner rvalid at r and IDLE at r+1. Minimum read occupancy is 3 cycles.
- Back-to-back: the next gnt can occur in the IDLE cycle immediately after completion.
- Simultaneous data and fetch requests resolve per starve_cnt. Ties between them are impossible since only one gnt is issued per IDLE cycle.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs 0.
  - An in-flight response is discarded; its later mem_rvalid_i is ignored.
  - No gnt or rvalid is issued during the reset cycle.

## Test plan
- Single fetch, addr 0x0000_0100, mem_gnt_i at 1st REQ cycle, rvalid 2 cycles later with 0xDEAD_BEEF:
  - instr_gnt_o at t, mem_req_o at t+1, mem_byte_en_o=WORD_ACCESS, mem_wr_o=0.
  - instr_rvalid_o for one cycle with instr_rdata_o=0xDEAD_BEEF; data_rvalid_o stays 0.
- Store, addr 0x10, data 0x0000_00AB, size BYTE_ACCESS, mem_gnt_i delayed 3 cycles:
  - mem_* fields stable for all 4 REQ cycles.
  - Back in IDLE one cycle after gnt; no rvalid on either port.
- Both ports request continuously, STARVE_MAX=4, 1-cycle memory:
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - starve_cnt clears after each fetch grant.
- Load returning 0x8000_00FF: data_rvalid_o pulses with data_rdata_o=0x8000_00FF (no extension); instr_rvalid_o stays 0.
- Spurious mem_rvalid_i in IDLE and in REQ: no rvalid pulses, and the FSM state is unchanged.
- Reset asserted in RESP of a fetch:
  - Next cycle is IDLE with all outputs 0.
  - A later mem_rvalid_i is ignored.
  - A new data request is then granted normally.
